// File: rtl/ad_regs_bank_if.sv
// fx-bus port bundle for one device register bank: write/read strobes, addresses,
// write data and registered read data.
interface ad_regs_bank_if;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [21:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;

    modport master (
        output fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd,
        input  fx_q
    );

    modport slave (
        input  fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd,
        output fx_q
    );
endinterface

// File: rtl/ad_regs_bank.sv
// Per-device fx-bus register bank: RW config registers with write strobes, RO status
// registers and a sticky event register with mask, W1C and optional clear-on-read.
module ad_regs_bank #(
    parameter int unsigned          N_CFG    = 8,
    parameter logic [15:0]          CFG_BASE = 16'h0080,
    parameter logic [8*N_CFG-1:0]   CFG_RST  = {8'h87, 8'h86, 8'h85, 8'h84,
                                                8'h83, 8'h82, 8'h81, 8'h80},
    parameter int unsigned          N_STS    = 4,
    parameter logic [15:0]          STS_BASE = 16'h0040,
    parameter logic [15:0]          EVT_ADDR = 16'h0010,
    parameter logic [15:0]          MSK_ADDR = 16'h0011,
    parameter bit                   EVT_COR  = 1'b0,
    parameter logic [7:0]           RD_DFLT  = 8'h55
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [5:0]           dev_id,
    ad_regs_bank_if.slave        fx,
    output logic [8*N_CFG-1:0]   cfg_q,
    output logic [N_CFG-1:0]     cfg_wstb,
    input  logic [8*N_STS-1:0]   sts_d,
    input  logic [7:0]           evt_in,
    output logic                 evt_irq
);

    localparam logic [15:0] N_CFG16 = 16'(N_CFG);
    localparam logic [15:0] N_STS16 = 16'(N_STS);

    logic                 now_wr;
    logic                 now_rd;
    logic [15:0]          woff;
    logic [15:0]          roff;
    logic [15:0]          w_cfg_idx;
    logic [15:0]          w_sts_idx;
    logic [15:0]          r_cfg_idx;
    logic [15:0]          r_sts_idx;

    logic [N_CFG-1:0]     wsel_cfg;
    logic                 w_evt;
    logic                 w_msk;
    logic                 r_evt;

    logic [8*N_CFG-1:0]   cfg_reg_q, cfg_reg_d;
    logic [N_CFG-1:0]     wstb_q;
    logic [7:0]           rdata_q, rdata_d;
    logic [7:0]           pend_q, pend_d;
    logic [7:0]           mask_q, mask_d;
    logic [7:0]           prev_q;
    logic                 irq_q, irq_d;
    logic [7:0]           rise;
    logic [7:0]           clr;

    assign now_wr = fx.fx_wr & (fx.fx_waddr[21:16] == dev_id);
    assign now_rd = fx.fx_rd & (fx.fx_raddr[21:16] == dev_id);
    assign woff   = fx.fx_waddr[15:0];
    assign roff   = fx.fx_raddr[15:0];

    // Window hits use wrapping subtraction so offsets below a base fall out of range.
    assign w_cfg_idx = woff - CFG_BASE;
    assign w_sts_idx = woff - STS_BASE;
    assign r_cfg_idx = roff - CFG_BASE;
    assign r_sts_idx = roff - STS_BASE;

    always_comb begin
        wsel_cfg = '0;
        w_evt    = 1'b0;
        w_msk    = 1'b0;
        if (now_wr) begin
            if (woff == 16'h0000) begin
                w_evt = 1'b0;
            end else if (woff == EVT_ADDR) begin
                w_evt = 1'b1;
            end else if (woff == MSK_ADDR) begin
                w_msk = 1'b1;
            end else if (w_sts_idx < N_STS16) begin
                w_evt = 1'b0;
            end else if (w_cfg_idx < N_CFG16) begin
                for (int unsigned i = 0; i < N_CFG; i++) begin
                    if (w_cfg_idx == 16'(i)) begin
                        wsel_cfg[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cfg_reg_d = cfg_reg_q;
        for (int unsigned i = 0; i < N_CFG; i++) begin
            if (wsel_cfg[i]) begin
                cfg_reg_d[8*i +: 8] = fx.fx_data;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        r_evt   = 1'b0;
        if (now_rd) begin
            if (roff == 16'h0000) begin
                rdata_d = {2'b00, dev_id};
            end else if (roff == EVT_ADDR) begin
                rdata_d = pend_q;
                r_evt   = 1'b1;
            end else if (roff == MSK_ADDR) begin
                rdata_d = mask_q;
            end else if (r_sts_idx < N_STS16) begin
                for (int unsigned j = 0; j < N_STS; j++) begin
                    if (r_sts_idx == 16'(j)) begin
                        rdata_d = sts_d[8*j +: 8];
                    end
                end
            end else if (r_cfg_idx < N_CFG16) begin
                for (int unsigned i = 0; i < N_CFG; i++) begin
                    if (r_cfg_idx == 16'(i)) begin
                        rdata_d = cfg_reg_q[8*i +: 8];
                    end
                end
            end else begin
                rdata_d = RD_DFLT;
            end
        end
    end

    // Clear-on-read drops only what the read returned; a rise on the same edge wins.
    always_comb begin
        rise = evt_in & ~prev_q;
        clr  = '0;
        if (w_evt) begin
            clr = clr | fx.fx_data;
        end
        if (EVT_COR && r_evt) begin
            clr = clr | pend_q;
        end
        pend_d = (pend_q & ~clr) | rise;
        mask_d = w_msk ? fx.fx_data : mask_q;
        irq_d  = |(pend_d & mask_d);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg_q <= CFG_RST;
            wstb_q    <= '0;
            rdata_q   <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            cfg_reg_q <= cfg_reg_d;
            wstb_q    <= wsel_cfg;
            rdata_q   <= rdata_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            prev_q    <= evt_in;
            irq_q     <= irq_d;
        end
    end

    assign cfg_q    = cfg_reg_q;
    assign cfg_wstb = wstb_q;
    assign fx.fx_q  = rdata_q;
    assign evt_irq  = irq_q;

endmodule

// File: tb/tb_ad_regs_bank.sv
// Bench for ad_regs_bank: two instances (clear-on-read off/on) share one stimulus stream
// and are checked every cycle against a register-map model, plus literal spot checks.
module tb_ad_regs_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  dev_id = 6'h05;
    logic [21:0] waddr, raddr;
    logic        wr, rd;
    logic [7:0]  wdata;
    logic [31:0] sts;
    logic [7:0]  evt;

    logic [63:0] cfg0, cfg1;
    logic [7:0]  stb0, stb1;
    logic        irq0, irq1;

    int n_chk;
    int n_fail;

    always #5 clk = ~clk;

    ad_regs_bank_if bus0 ();
    ad_regs_bank_if bus1 ();

    assign bus0.fx_waddr = waddr;
    assign bus0.fx_wr    = wr;
    assign bus0.fx_data  = wdata;
    assign bus0.fx_raddr = raddr;
    assign bus0.fx_rd    = rd;
    assign bus1.fx_waddr = waddr;
    assign bus1.fx_wr    = wr;
    assign bus1.fx_data  = wdata;
    assign bus1.fx_raddr = raddr;
    assign bus1.fx_rd    = rd;

    ad_regs_bank #(.EVT_COR(1'b0)) dut0 (
        .clk_sys(clk), .rst_n(rst_n), .dev_id(dev_id), .fx(bus0),
        .cfg_q(cfg0), .cfg_wstb(stb0), .sts_d(sts), .evt_in(evt), .evt_irq(irq0)
    );

    ad_regs_bank #(.EVT_COR(1'b1)) dut1 (
        .clk_sys(clk), .rst_n(rst_n), .dev_id(dev_id), .fx(bus1),
        .cfg_q(cfg1), .cfg_wstb(stb1), .sts_d(sts), .evt_in(evt), .evt_irq(irq1)
    );

    // Model state; index k selects the instance (0: no clear-on-read, 1: clear-on-read).
    logic [7:0] m_cfg [8];
    logic [7:0] m_mask;
    logic [7:0] m_prev;
    logic [7:0] m_wstb;
    logic [7:0] m_pend [2];
    logic       m_irq  [2];
    logic [7:0] m_fxq  [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cfg[i] = 8'(8'h80 + i);
        m_mask = '0;
        m_prev = '0;
        m_wstb = '0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0;
            m_irq[k]  = 1'b0;
            m_fxq[k]  = '0;
        end
    endtask

    task automatic model_step();
        logic [7:0] rv [2];
        logic [7:0] rise, clr;
        int         woff, roff;
        bit         nw, nr;
        nw   = wr && (waddr[21:16] == dev_id);
        nr   = rd && (raddr[21:16] == dev_id);
        woff = int'(waddr[15:0]);
        roff = int'(raddr[15:0]);
        for (int k = 0; k < 2; k++) begin
            if (!nr)                         rv[k] = 8'h00;
            else if (roff == 0)              rv[k] = {2'b00, dev_id};
            else if (roff == 'h10)           rv[k] = m_pend[k];
            else if (roff == 'h11)           rv[k] = m_mask;
            else if (roff >= 'h40 && roff < 'h44) rv[k] = sts[8*(roff-'h40) +: 8];
            else if (roff >= 'h80 && roff < 'h88) rv[k] = m_cfg[roff-'h80];
            else                             rv[k] = 8'h55;
        end
        m_wstb = '0;
        if (nw && woff >= 'h80 && woff < 'h88) begin
            m_cfg[woff-'h80] = wdata;
            m_wstb = 8'(1 << (woff - 'h80));
        end
        if (nw && woff == 'h11) m_mask = wdata;
        rise = evt & ~m_prev;
        for (int k = 0; k < 2; k++) begin
            clr = (nw && woff == 'h10) ? wdata : 8'h00;
            if (k == 1 && nr && roff == 'h10) clr = clr | m_pend[k];
            m_pend[k] = (m_pend[k] & ~clr) | rise;
            m_irq[k]  = |(m_pend[k] & m_mask);
            m_fxq[k]  = rv[k];
        end
        m_prev = evt;
    endtask

    function automatic logic [63:0] m_cfg_flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_cfg[i];
        return r;
    endfunction

    task automatic cmp_all();
        chk("fx_q0",    {56'h0, bus0.fx_q}, {56'h0, m_fxq[0]});
        chk("fx_q1",    {56'h0, bus1.fx_q}, {56'h0, m_fxq[1]});
        chk("cfg_q0",   cfg0, m_cfg_flat());
        chk("cfg_q1",   cfg1, m_cfg_flat());
        chk("cfg_wstb0", {56'h0, stb0}, {56'h0, m_wstb});
        chk("cfg_wstb1", {56'h0, stb1}, {56'h0, m_wstb});
        chk("evt_irq0", {63'h0, irq0}, {63'h0, m_irq[0]});
        chk("evt_irq1", {63'h0, irq1}, {63'h0, m_irq[1]});
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        cmp_all();
    endtask

    task automatic read_cyc(input logic [21:0] a);
        raddr = a;
        rd    = 1'b1;
        cyc();
        rd    = 1'b0;
    endtask

    task automatic write_cyc(input logic [21:0] a, input logic [7:0] d);
        waddr = a;
        wdata = d;
        wr    = 1'b1;
        cyc();
        wr    = 1'b0;
    endtask

    function automatic logic [21:0] gen_addr();
        int          s;
        logic [5:0]  d;
        logic [15:0] o;
        s = int'($urandom % 8);
        d = ($urandom % 4 == 0) ? 6'($urandom) : 6'h05;
        case (s)
            0:       o = 16'h0000;
            1:       o = 16'h0010;
            2:       o = 16'h0011;
            3:       o = 16'(16'h0040 + ($urandom % 5));
            4, 5:    o = 16'(16'h0080 + ($urandom % 9));
            6:       o = 16'($urandom);
            default: o = 16'h0010;
        endcase
        return {d, o};
    endfunction

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_cfg0"}, cfg0, 64'h8786858483828180);
        chk({tag, "_cfg1"}, cfg1, 64'h8786858483828180);
        chk({tag, "_stb0"}, {56'h0, stb0}, 64'h0);
        chk({tag, "_fxq0"}, {56'h0, bus0.fx_q}, 64'h0);
        chk({tag, "_fxq1"}, {56'h0, bus1.fx_q}, 64'h0);
        chk({tag, "_irq0"}, {63'h0, irq0}, 64'h0);
        chk({tag, "_irq1"}, {63'h0, irq1}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        waddr  = '0;
        raddr  = '0;
        wr     = 1'b0;
        rd     = 1'b0;
        wdata  = '0;
        sts    = '0;
        evt    = '0;
        model_reset();

        #12;
        chk("rst_cfg_q", cfg0, 64'h8786858483828180);
        chk("rst_fx_q", {56'h0, bus0.fx_q}, 64'h0);
        chk("rst_wstb", {56'h0, stb0}, 64'h0);
        chk("rst_irq", {63'h0, irq0}, 64'h0);
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            read_cyc(22'(22'h050080 + i));
            chk("lit_cfg_read", {56'h0, bus0.fx_q}, 64'(8'h80 + i));
            cyc();
            chk("lit_idle_fxq", {56'h0, bus0.fx_q}, 64'h0);
        end
        read_cyc(22'h050000);
        chk("lit_devid", {56'h0, bus0.fx_q}, 64'h05);
        read_cyc(22'h050123);
        chk("lit_dflt", {56'h0, bus0.fx_q}, 64'h55);
        read_cyc(22'h060080);
        chk("lit_foreign_rd", {56'h0, bus0.fx_q}, 64'h0);

        write_cyc(22'h050083, 8'hA5);
        chk("lit_cfg3", {56'h0, cfg0[31:24]}, 64'hA5);
        chk("lit_wstb3", {56'h0, stb0}, 64'h08);
        cyc();
        chk("lit_wstb_off", {56'h0, stb0}, 64'h0);
        write_cyc(22'h060083, 8'h11);
        chk("lit_foreign_wr", {56'h0, cfg0[31:24]}, 64'hA5);
        chk("lit_foreign_stb", {56'h0, stb0}, 64'h0);

        sts = 32'h0000_3C00;
        read_cyc(22'h050041);
        chk("lit_sts1", {56'h0, bus0.fx_q}, 64'h3C);
        write_cyc(22'h050041, 8'hFF);
        chk("lit_sts_wr_stb", {56'h0, stb0}, 64'h0);
        read_cyc(22'h050041);
        chk("lit_sts1_again", {56'h0, bus0.fx_q}, 64'h3C);

        write_cyc(22'h050011, 8'h01);
        evt = 8'h01;
        cyc();
        chk("lit_irq_set", {63'h0, irq0}, 64'h1);
        evt = 8'h00;
        cyc();
        evt = 8'h01;
        write_cyc(22'h050010, 8'h01);
        read_cyc(22'h050010);
        chk("lit_set_wins", {56'h0, bus0.fx_q}, 64'h01);
        chk("lit_irq_hold", {63'h0, irq0}, 64'h1);

        evt = 8'h00;
        write_cyc(22'h050010, 8'hFF);
        evt = 8'h06;
        cyc();
        read_cyc(22'h050010);
        chk("lit_cor_read", {56'h0, bus1.fx_q}, 64'h06);
        read_cyc(22'h050010);
        chk("lit_cor_cleared", {56'h0, bus1.fx_q}, 64'h00);
        chk("lit_nocor_kept", {56'h0, bus0.fx_q}, 64'h06);
        evt = 8'h00;
        cyc();
        evt = 8'h06;
        cyc();
        evt = 8'h0E;
        read_cyc(22'h050010);
        chk("lit_cor_read2", {56'h0, bus1.fx_q}, 64'h06);
        read_cyc(22'h050010);
        chk("lit_cor_rise_kept", {56'h0, bus1.fx_q}, 64'h08);

        evt = 8'h00;
        cyc();
        for (int i = 0; i < 4; i++) begin
            waddr = 22'(22'h050080 + i);
            wdata = 8'($urandom);
            wr    = 1'b1;
            raddr = 22'h050011;
            rd    = 1'b1;
            evt   = 8'h01;
            cyc();
        end
        #2;
        async_reset_check("mid_burst");
        wr = 1'b0;
        rd = 1'b0;
        cyc();
        rst_n = 1'b1;
        read_cyc(22'h050010);
        chk("lit_pend_rst", {56'h0, bus0.fx_q}, 64'h0);
        read_cyc(22'h050011);
        chk("lit_mask_rst", {56'h0, bus0.fx_q}, 64'h0);

        for (int n = 0; n < 3000; n++) begin
            wr    = ($urandom % 3 == 0);
            waddr = gen_addr();
            wdata = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
            rd    = ($urandom % 2 == 0);
            raddr = gen_addr();
            sts   = $urandom;
            if ($urandom % 3 == 0) evt = 8'($urandom);
            if (n == 1500) begin
                #3;
                async_reset_check("rand_rst");
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ad_regs_bank.md
Name: ad_regs_bank

Overview:
- Parametrised successor of the per-device fx-bus register file.
- Decodes fx-bus reads and writes for one device slot, selected by fx_*addr[21:16] == dev_id.
- Provides:
  - N_CFG read/write config registers with per-register write strobes.
  - N_STS read-only status registers.
  - An 8-bit sticky event register with interrupt mask, W1C clear and optional clear-on-read.
- Sits between the fx-bus fabric and a device datapath (AD front end or similar).

Parameters:
- N_CFG, 8: number of RW config registers (1..32).
- CFG_BASE, 16'h0080: offset of config register 0; register i is at CFG_BASE+i.
- CFG_RST, {8'h87,8'h86,8'h85,8'h84,8'h83,8'h82,8'h81,8'h80}: flat 8*N_CFG reset vector; byte i is the reset value of register i.
- N_STS, 4: number of RO status registers (1..32); register j is at STS_BASE+j.
- STS_BASE, 16'h0040: offset of status register 0.
- EVT_ADDR, 16'h0010: offset of the event pending register.
- MSK_ADDR, 16'h0011: offset of the event mask register.
- EVT_COR, 0: 1 = reading EVT_ADDR clears the bits returned.
- RD_DFLT, 8'h55: value returned for an unmapped offset inside the device window.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dev_id  in  6  device slot id; static after reset.
- fx_waddr  in  22  write address: [21:16] device, [15:0] offset.
- fx_wr  in  1  write strobe, one cycle per write.
- fx_data  in  8  write data.
- fx_raddr  in  22  read address.
- fx_rd  in  1  read strobe, one cycle per read.
- fx_q  out  8  read data, registered.
- cfg_q  out  8*N_CFG  config register contents; byte i = register i.
- cfg_wstb  out  N_CFG  one-cycle pulse per config register written.
- sts_d  in  8*N_STS  live status values from the datapath.
- evt_in  in  8  event level inputs, synchronous to clk_sys.
- evt_irq  out  1  registered interrupt: OR of pending & mask.

Behaviour:
- Reset (async assert, sync release):
  - cfg_q = CFG_RST; cfg_wstb = 0; fx_q = 0.
  - evt_pend = 0; evt_mask = 0; evt_prev = 0; evt_irq = 0.
- Select:
  - now_wr = fx_wr & (fx_waddr[21:16] == dev_id).
  - now_rd = fx_rd & (fx_raddr[21:16] == dev_id).
- Write decode (offset fx_waddr[15:0]):
  - CFG_BASE+i, i < N_CFG: register i <= fx_data on the same edge; cfg_wstb[i] = 1 for exactly the following cycle, aligned with the new cfg_q value.
  - MSK_ADDR: evt_mask <= fx_data.
  - EVT_ADDR: W1C; evt_pend bits set in fx_data are cleared.
  - Offset 0, status and unmapped offsets: write ignored, no strobe.
- Read decode (offset fx_raddr[15:0]), 1-cycle latency:
  - fx_q is valid the cycle after fx_rd.
  - Returns by offset:
    - 0: {2'b00, dev_id}.
    - EVT_ADDR: evt_pend.
    - MSK_ADDR: evt_mask.
    - STS_BASE+j: sts_d byte j, sampled at the read edge.
    - CFG_BASE+i: register i.
    - Anything else: RD_DFLT.
  - fx_q = 0 in every cycle without now_rd, including foreign dev_id.
  - Decode precedence if windows overlap: 0, EVT_ADDR, MSK_ADDR, STS, CFG.
- Events:
  - evt_prev <= evt_in every cycle.
  - rise = evt_in & ~evt_prev; evt_pend bit sets on rise.
  - Clear sources:
    - W1C write to EVT_ADDR.
    - Read of EVT_ADDR when EVT_COR = 1; clears only the bits actually returned, i.e. pend before this edge.
  - Set and clear on the same edge: set wins; bit stays 1.
  - evt_irq <= |(evt_pend_next & evt_mask_next); this is a 1-cycle registered delay from the pend or mask change.
- Simultaneous operations:
  - Read and write of the same register in one cycle: read returns the old value; the write takes effect.
  - Write to a foreign dev_id: no state change.
- Reset mid-operation: all state returns to reset values immediately; a pending strobe or read is dropped.

Test Plan:
- Reset, dev_id = 6'h05; read 0x05_0080..0x05_0087 -> fx_q = 0x80..0x87 one cycle after each rd; read 0x05_0000 -> 0x05; read 0x05_0123 -> 0x55; fx_q = 0 between reads.
- Write 0xA5 to 0x05_0083 -> cfg_q byte3 = 0xA5 and cfg_wstb = 8'h08 for one cycle; write 0x11 to 0x06_0083 -> no change, no strobe.
- Drive sts_d byte1 = 0x3C, read 0x05_0041 -> 0x3C; write 0xFF to 0x05_0041 -> ignored, no strobe, value unchanged.
- Set mask 0x01; pulse evt_in[0] -> pend = 0x01, evt_irq = 1 one cycle later; W1C write 0x01 coincident with a new evt_in[0] rise -> pend stays 0x01.
- With EVT_COR = 1: pend = 0x06, read EVT_ADDR -> fx_q = 0x06 and pend = 0 next cycle; repeat with evt_in[3] rising on the read edge -> fx_q = 0x06, pend = 0x08 afterwards.
- Assert rst_n low mid-write burst -> cfg_q returns to CFG_RST; cfg_wstb, fx_q, evt_pend, evt_mask and evt_irq all 0 immediately.
